// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the parametrised register file.
package regfile_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int NUM_RD     = 2;

endpackage

// File: rtl/regfile_init_seq.sv
// Clear sequencer: walks every address once after reset, then holds RUN with ready high.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              i_rst_n,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_ready
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_ready;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ADDR) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_clr_we   = (r_state == ST_INIT);
  assign o_clr_addr = r_cnt;
  assign o_ready    = r_ready;

endmodule

// File: rtl/regfile_param.sv
// Two-read/one-write register file with forwarding, pending-write scoreboard and clear sequence.
// Optional build macro REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              pend1,
  output logic              pend2,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_ready;
  logic              w_wr_en;
  logic              w_rsv_en;
  logic [DEPTH-1:0]  r_pend;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] w_raddr [NUM_RD];
  logic [DATA_W-1:0] w_rdata [NUM_RD];
  logic              w_pend  [NUM_RD];

  regfile_init_seq #(
    .ADDR_W (ADDR_W)
  ) u_init_seq (
    .clk        (clk),
    .i_rst_n    (reset),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr),
    .o_ready    (w_ready)
  );

  assign w_wr_en  = w_ready && we     && !(ZERO_REG && (waddr    == '0));
  assign w_rsv_en = w_ready && rsv_en && !(ZERO_REG && (rsv_addr == '0));

  // Storage is deliberately not reset; the clear sequence owns initialisation.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= INIT_VAL;
    end else if (w_wr_en) begin
      r_mem[waddr] <= wdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_pend
      // A reservation landing on the same edge as the write keeps the bit set.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_pend[gi] <= 1'b0;
        end else if (w_rsv_en && (rsv_addr == ADDR_W'(gi))) begin
          r_pend[gi] <= 1'b1;
        end else if (w_wr_en && (waddr == ADDR_W'(gi))) begin
          r_pend[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign w_raddr[0] = raddr1;
  assign w_raddr[1] = raddr2;

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      always_comb begin
        w_rdata[gi] = '0;
        w_pend[gi]  = 1'b0;
        if (w_ready) begin
          w_pend[gi] = r_pend[w_raddr[gi]];
          if (ZERO_REG && (w_raddr[gi] == '0)) begin
            w_rdata[gi] = '0;
          end else if (w_wr_en && (waddr == w_raddr[gi])) begin
            w_rdata[gi] = wdata;
          end else begin
            w_rdata[gi] = r_mem[w_raddr[gi]];
          end
        end
      end
    end
  endgenerate

  assign rdata1 = w_rdata[0];
  assign rdata2 = w_rdata[1];
  assign pend1  = w_pend[0];
  assign pend2  = w_pend[1];
  assign ready  = w_ready;

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised, two-read/one-write register file for the processor datapath, next generation of the 8×8 single-port register file. Sits between instruction decode and the ALU: decode supplies register addresses, writeback supplies write data. Adds configurable width/depth, same-cycle write-to-read forwarding, a pending-write scoreboard for multi-cycle producers, and a hardware clear sequence that replaces file-based initialisation on reset.

## Interface
Parameters:
- DATA_W, 8, register width in bits
- ADDR_W, 3, address width; depth DEPTH = 2**ADDR_W
- INIT_VAL, 0, value written to every register by the clear sequence (DATA_W bits)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- raddr1  in  ADDR_W  read port 1 address
- raddr2  in  ADDR_W  read port 2 address
- rdata1  out  DATA_W  read port 1 data (combinational)
- rdata2  out  DATA_W  read port 2 data (combinational)
- rsv_en  in  1  mark rsv_addr as awaiting a write
- rsv_addr  in  ADDR_W  register being reserved
- pend1  out  1  raddr1 has an outstanding reservation
- pend2  out  1  raddr2 has an outstanding reservation
- ready  out  1  clear sequence complete; file usable

## Operation
- States: INIT, RUN. reset low → INIT, clear counter = 0, all pending bits = 0, ready = 0, asynchronously, at any time including mid-sequence or mid-write.
- INIT: each cycle writes INIT_VAL to reg[counter], counter increments. On the cycle counter = DEPTH-1 is written, next state RUN. we and rsv_en ignored in INIT.
- RUN: ready = 1. we=1 writes wdata to reg[waddr] at the edge and clears pending[waddr].
- rsv_en=1 sets pending[rsv_addr]. Same cycle as a write to the same address: reservation wins (pending stays 1, data still written).
- Read: rdataN = wdata if we && waddr == raddrN in RUN (forwarding), else reg[raddrN]. raddr1 == raddr2 legal; both return same value.
- pendN = pending[raddrN], not masked by forwarding: a write this cycle still shows pend until the edge.
- While ready = 0: rdata1, rdata2, pend1, pend2 forced to 0.
- Array contents are not reset directly; only the clear sequence initialises them.

## Timing
- Reset values: ready 0, rdata1/2 0, pend1/2 0.
- Clear latency: ready rises exactly DEPTH rising edges after reset deasserts (first edge with reset high writes reg[0]).
- Read latency 0 (combinational); write visible via array on the cycle after the edge, via forwarding the same cycle.
- Reservation visible on pendN the cycle after rsv_en.

## Configuration
- REGFILE_ZERO_REG_EN defined: register 0 hardwired to zero; writes to address 0 discarded; rsv_en to address 0 ignored; pend is never 1 and rdata is 0 (no forwarding) for address 0. The clear sequence still runs for DEPTH cycles.
- Undefined: register 0 is an ordinary register.

## Structure
- Package regfile_pkg: state typedef (INIT, RUN), default DATA_W/ADDR_W constants.
- Sub-module regfile_init_seq: INIT/RUN state machine, clear counter, outputs clear write enable/address and ready.

## Test plan
- Reset low 2 cycles then high, DATA_W=8, ADDR_W=3, INIT_VAL=8'h5A → ready rises after 8 edges; all 8 registers read 8'h5A.
- RUN: we=1, waddr=3, wdata=8'hC4, raddr1=3 in same cycle → rdata1=8'hC4 same cycle; next cycle with we=0 still 8'hC4.
- rsv_en, rsv_addr=5 → pend2=1 next cycle with raddr2=5; write 8'h11 to 5 → pend2=0 next cycle, rdata2=8'h11. Repeat with rsv_en and we to 5 on the same edge → pend2 remains 1.
- Assert reset at the 4th clear cycle, and again after writes in RUN → ready, pend1/2 and rdata1/2 go 0 immediately; full 8-cycle clear restarts; earlier data replaced by INIT_VAL.
- we=1 during INIT, waddr=2, wdata=8'hFF → ignored; reg 2 reads INIT_VAL after ready.
- With REGFILE_ZERO_REG_EN: write 8'h77 to 0, rsv_en to 0, same-cycle read of 0 → rdata 0, pend 0 throughout.
